// File: rtl/spi_controller_pkg.sv
// spi_controller_pkg: shared types and constants for the SPI register-access
// controller.
//   state_t      - controller states (IDLE, SHIFT, HOLD, GAP)
//   FRAME_BITS   - serial frame length
//   ADDR_BITS    - register address width
//   DATA_BITS    - register data width
//   build_frame  - packs {rw, addr, data} into one frame; reads carry 0x00
package spi_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 rw,
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] data
  );
    return {rw, addr, rw ? data : {DATA_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_controller_sclk_gen.sv
// spi_sclk_gen: serial-clock edge strobe generator.
// Produces single-cycle rise/fall strobes, alternating, one every CLK_DIV
// clk cycles while en is high. Counter and phase are held cleared while en
// is low, so every enable window starts with a full half-period and a rise.
//   clk, rst - clock, synchronous active-high reset
//   en       - run enable (high only while shifting)
//   rise     - strobe: SCLK goes high on the next clk edge
//   fall     - strobe: SCLK goes low on the next clk edge
module spi_sclk_gen
  import spi_controller_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase;
  logic       tick;

  // With CLK_DIV=1 TERM is 0: cnt stays at 0 and tick fires every cycle.
  assign tick = en && (cnt == TERM);
  assign rise = tick && !phase;
  assign fall = tick && phase;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= 8'd0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= 8'd0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: single-command SPI mode-0 register access controller.
// Sends a 16-bit frame {rw, addr[6:0], data[7:0]} MSB first, then holds
// ncs low for one more half-period, raises ncs and keeps it high for at
// least CS_GAP cycles before accepting the next command.
// Optional feature macro SPI_CONTROLLER_READBACK_EN: when defined, req_rw
// is honoured and cipo is sampled on each SCLK rise; a read frame returns
// the last 8 samples on rsp_data with rsp_valid pulsing alongside done.
// When undefined every frame is a write and the response outputs are 0.
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - command handshake
//   req_rw, req_addr, req_data - command fields, captured on accept
//   done                - one-cycle pulse when ncs rises
//   rsp_data, rsp_valid - read result and its qualifier
//   sclk, copi, ncs     - SPI outputs; cipo - SPI input
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo
);

  localparam logic [7:0] HOLD_END = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_END  = 8'(CS_GAP - 1);

  state_t                  state;
  state_t                  next_state;
  logic [7:0]              cnt;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   sh;
  logic                    sclk_q;
  logic                    done_q;
  logic                    rise;
  logic                    fall;
  logic                    accept;
  logic                    last_fall;
  logic                    frame_end;
  logic                    rw_eff;

  assign accept    = req_ready && req_valid;
  assign last_fall = fall && (bit_cnt == 4'd15);
  assign frame_end = (state == HOLD) && (next_state == GAP);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .rise (rise),
    .fall (fall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)       next_state = SHIFT;
      SHIFT:   if (last_fall)       next_state = HOLD;
      HOLD:    if (cnt == HOLD_END) next_state = GAP;
      GAP:     if (cnt == GAP_END)  next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    ncs       = !((state == SHIFT) || (state == HOLD));
    sclk      = sclk_q;
    copi      = (state == SHIFT) && sh[FRAME_BITS-1];
    done      = done_q;
  end

  // Control registers; cnt restarts at 0 on every state change so it
  // measures the time spent in HOLD and GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 8'd0;
      bit_cnt <= 4'd0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt     <= ((state == IDLE) || (next_state != state)) ? 8'd0 : cnt + 8'd1;
      if (accept)    bit_cnt <= 4'd0;
      else if (fall) bit_cnt <= bit_cnt + 4'd1;
      sclk_q  <= (state == SHIFT) && (rise || (sclk_q && !fall));
      done_q  <= frame_end;
    end
  end

  // Transmit shift register; zeros fill in behind the frame.
  always_ff @(posedge clk) begin
    if (accept)    sh <= build_frame(rw_eff, req_addr, req_data);
    else if (fall) sh <= {sh[FRAME_BITS-2:0], 1'b0};
  end

`ifdef SPI_CONTROLLER_READBACK_EN
  logic [DATA_BITS-1:0] rx;
  logic [DATA_BITS-1:0] rsp_q;
  logic                 rsp_valid_q;
  logic                 is_read;

  assign rw_eff = req_rw;

  always_ff @(posedge clk) begin
    if (accept) is_read <= !req_rw;
    if (rise)   rx      <= {rx[DATA_BITS-2:0], cipo};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= frame_end && is_read;
      if (frame_end && is_read) rsp_q <= rx;
    end
  end

  assign rsp_data  = rsp_q;
  assign rsp_valid = rsp_valid_q;
`else
  logic unused_inputs;

  assign rw_eff        = 1'b1;
  assign rsp_data      = '0;
  assign rsp_valid     = 1'b0;
  assign unused_inputs = ^{cipo, req_rw};
`endif

endmodule
